// File: rtl/fmap_stream_reader.sv
// Streams one square feature map from a synchronous-read RAM in row-major order.
// Reads are credit-limited so the 4-entry output FIFO can never overflow.
`timescale 1ns/1ps
module fmap_stream_reader #(
   parameter int DATA_WIDTH        = 8,
   parameter int ADDR_WIDTH        = 11,
   parameter int FEATURE_MAP1_SIZE = 32,
   parameter int FEATURE_MAP2_SIZE = 28,
   parameter int FEATURE_MAP3_SIZE = 14,
   parameter int FEATURE_MAP4_SIZE = 10,
   parameter int FEATURE_MAP5_SIZE = 5,
   parameter int RAM_LATENCY       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            mode,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  err_mode,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [5:0]            m_row,
   output logic [5:0]            m_col,
   output logic                  m_last
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   // Tag layout: {row[12:7], col[6:1], last[0]}
   localparam int TAG_W   = 13;
   localparam int ENTRY_W = DATA_WIDTH + TAG_W;

   state_t                            state, state_nxt;
   logic [5:0]                        mode_size, size_q, row_q, col_q;
   logic [ADDR_WIDTH-1:0]             addr_q;
   logic                              legal_mode, accept, issue_last;
   logic                              fifo_wr, fifo_rd, last_xfer;
   logic [RAM_LATENCY-1:0]            pipe_v;
   logic [RAM_LATENCY-1:0][TAG_W-1:0] pipe_tag;
   logic [2:0]                        inflight, fifo_cnt;
   logic [1:0]                        wr_ptr, rd_ptr;
   logic [ENTRY_W-1:0]                fifo_mem [4];
   logic [ENTRY_W-1:0]                head;

   always_comb begin
      mode_size = 6'd0;
      case (mode)
         3'd0:    mode_size = 6'(FEATURE_MAP1_SIZE);
         3'd1:    mode_size = 6'(FEATURE_MAP2_SIZE);
         3'd2:    mode_size = 6'(FEATURE_MAP3_SIZE);
         3'd3:    mode_size = 6'(FEATURE_MAP4_SIZE);
         3'd4:    mode_size = 6'(FEATURE_MAP5_SIZE);
         default: mode_size = 6'd0;
      endcase
   end

   assign legal_mode = (mode <= 3'd4);
   assign busy       = (state == S_READ) || (state == S_DRAIN);
   assign done       = (state == S_DONE);
   assign accept     = start && !busy && legal_mode;

   always_comb begin
      inflight = 3'd0;
      for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + {2'b00, pipe_v[i]};
   end

   // Every issued read owns a FIFO slot until its beat is transferred.
   assign ram_en     = (state == S_READ) && (({1'b0, inflight} + {1'b0, fifo_cnt}) < 4'd4);
   assign ram_addr   = addr_q;
   assign issue_last = (row_q == size_q - 6'd1) && (col_q == size_q - 6'd1);

   // Handshake: a beat moves on a rising edge where m_valid and m_ready are both high;
   // m_valid never depends on m_ready, and the head entry holds until it moves.
   assign fifo_wr   = pipe_v[RAM_LATENCY-1];
   assign m_valid   = (fifo_cnt != 3'd0);
   assign fifo_rd   = m_valid && m_ready;
   assign head      = fifo_mem[rd_ptr];
   assign m_data    = m_valid ? head[ENTRY_W-1 -: DATA_WIDTH] : '0;
   assign m_row     = m_valid ? head[12:7] : 6'd0;
   assign m_col     = m_valid ? head[6:1] : 6'd0;
   assign m_last    = m_valid && head[0];
   assign last_xfer = fifo_rd && head[0];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_READ;
         S_READ:  if (ram_en && issue_last) state_nxt = S_DRAIN;
         S_DRAIN: if (last_xfer) state_nxt = S_DONE;
         S_DONE:  state_nxt = accept ? S_READ : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         err_mode <= 1'b0;
         size_q   <= 6'd0;
         row_q    <= 6'd0;
         col_q    <= 6'd0;
         addr_q   <= '0;
         pipe_v   <= '0;
         pipe_tag <= '0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         state    <= state_nxt;
         err_mode <= start && !busy && !legal_mode;

         if (accept) begin
            size_q <= mode_size;
            addr_q <= base_addr;
            row_q  <= 6'd0;
            col_q  <= 6'd0;
         end else if (ram_en) begin
            addr_q <= addr_q + 1'b1;
            if (col_q == size_q - 6'd1) begin
               col_q <= 6'd0;
               row_q <= row_q + 6'd1;
            end else begin
               col_q <= col_q + 6'd1;
            end
         end

         pipe_v[0]   <= ram_en;
         pipe_tag[0] <= {row_q, col_q, issue_last};
         for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end

         if (fifo_wr) wr_ptr <= wr_ptr + 2'd1;
         if (fifo_rd) rd_ptr <= rd_ptr + 2'd1;
         case ({fifo_wr, fifo_rd})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Storage needs no reset: outputs are gated by m_valid.
   always_ff @(posedge clk) begin
      if (!rst && fifo_wr) fifo_mem[wr_ptr] <= {ram_dout, pipe_tag[RAM_LATENCY-1]};
   end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Bench for fmap_stream_reader: two instances (RAM latency 1 and 2) share stimulus and
// a RAM image; the selected one is checked against a row-major pixel model.
`timescale 1ns/1ps
module tb_fmap_stream_reader;

   localparam int DW = 8;
   localparam int AW = 11;

   logic          clk = 1'b0;
   logic          rst, start, m_ready;
   logic [2:0]    mode;
   logic [AW-1:0] base_addr;

   logic          busy_a, done_a, err_a, ram_en_a, m_valid_a, m_last_a;
   logic [AW-1:0] ram_addr_a;
   logic [DW-1:0] ram_dout_a, m_data_a;
   logic [5:0]    m_row_a, m_col_a;
   logic          busy_b, done_b, err_b, ram_en_b, m_valid_b, m_last_b;
   logic [AW-1:0] ram_addr_b;
   logic [DW-1:0] ram_dout_b, m_data_b, ram_stage_b;
   logic [5:0]    m_row_b, m_col_b;

   logic          sel_b = 1'b0;
   logic          obs_busy, obs_done, obs_err, obs_ram_en, obs_m_valid, obs_m_last;
   logic [AW-1:0] obs_ram_addr;
   logic [DW-1:0] obs_m_data;
   logic [5:0]    obs_m_row, obs_m_col;

   logic [DW-1:0] mem [2048];
   logic [20:0]   exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   int            checks = 0;
   int            errors = 0;

   // ---------------- clock / reset / DUTs ----------------
   always #5 clk = ~clk;

   fmap_stream_reader #(.RAM_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
      .busy(busy_a), .done(done_a), .err_mode(err_a), .ram_en(ram_en_a),
      .ram_addr(ram_addr_a), .ram_dout(ram_dout_a), .m_valid(m_valid_a),
      .m_ready(m_ready), .m_data(m_data_a), .m_row(m_row_a), .m_col(m_col_a),
      .m_last(m_last_a));

   fmap_stream_reader #(.RAM_LATENCY(2)) dut_b (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
      .busy(busy_b), .done(done_b), .err_mode(err_b), .ram_en(ram_en_b),
      .ram_addr(ram_addr_b), .ram_dout(ram_dout_b), .m_valid(m_valid_b),
      .m_ready(m_ready), .m_data(m_data_b), .m_row(m_row_b), .m_col(m_col_b),
      .m_last(m_last_b));

   always @(posedge clk) begin
      if (ram_en_a) ram_dout_a <= mem[ram_addr_a];
      if (ram_en_b) ram_stage_b <= mem[ram_addr_b];
      ram_dout_b <= ram_stage_b;
   end

   assign obs_busy     = sel_b ? busy_b     : busy_a;
   assign obs_done     = sel_b ? done_b     : done_a;
   assign obs_err      = sel_b ? err_b      : err_a;
   assign obs_ram_en   = sel_b ? ram_en_b   : ram_en_a;
   assign obs_ram_addr = sel_b ? ram_addr_b : ram_addr_a;
   assign obs_m_valid  = sel_b ? m_valid_b  : m_valid_a;
   assign obs_m_data   = sel_b ? m_data_b   : m_data_a;
   assign obs_m_row    = sel_b ? m_row_b    : m_row_a;
   assign obs_m_col    = sel_b ? m_col_b    : m_col_a;
   assign obs_m_last   = sel_b ? m_last_b   : m_last_a;

   function automatic int size_of(input int m);
      case (m)
         0: return 32;
         1: return 28;
         2: return 14;
         3: return 10;
         default: return 5;
      endcase
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
   endtask

   // ---------------- streaming scenario with scoreboard ----------------
   task automatic test_stream(input string name, input bit use_b, input int m, input int base,
                              input int ready_pct, input int poke_n, input int poke_mode);
      int s, lat, n, first_n, last_n, issued, xfer, a;
      bit got_last, finished, prev_stall;
      logic [20:0] obs, exp, held;
      logic [AW-1:0] exp_a;
      logic [5:0] r6, c6;
      s = size_of(m);
      lat = use_b ? 2 : 1;
      sel_b = use_b;
      exp_q.delete();
      exp_addr_q.delete();
      for (int k = 0; k < s * s; k++) begin
         a = (base + k) % 2048;
         r6 = 6'(k / s);
         c6 = 6'(k % s);
         exp_addr_q.push_back(AW'(a));
         exp_q.push_back({mem[a], r6, c6, (k == s * s - 1)});
      end
      @(negedge clk);
      start = 1'b1; mode = 3'(m); base_addr = AW'(base); m_ready = 1'b1;
      @(posedge clk);
      n = 0; first_n = -1; last_n = -1; issued = 0; xfer = 0;
      got_last = 0; finished = 0; prev_stall = 0; held = '0;
      while (!finished && n < 6000) begin
         @(negedge clk);
         start = (n == poke_n);
         if (start) begin
            mode = 3'(poke_mode);
            base_addr = AW'(base) ^ 11'h155;
         end
         m_ready = ($urandom_range(99) < ready_pct);
         #1;
         obs = {obs_m_data, obs_m_row, obs_m_col, obs_m_last};
         if (prev_stall) begin
            checks++;
            if (obs_m_valid !== 1'b1 || obs !== held) begin
               errors++;
               $display("FAIL %s stall_hold n=%0d: got v=%b %h, need v=1 %h", name, n, obs_m_valid, obs, held);
            end
         end
         checks++;
         if (obs_err !== 1'b0) begin
            errors++;
            $display("FAIL %s err_while_busy n=%0d: got %b, need 0", name, n, obs_err);
         end
         if (obs_done === 1'b1) begin
            checks++;
            if (!got_last || n != last_n + 1) begin
               errors++;
               $display("FAIL %s done_timing: got n=%0d, need n=%0d (last seen=%0b)", name, n, last_n + 1, got_last);
            end
            checks++;
            if (obs_busy !== 1'b0) begin
               errors++;
               $display("FAIL %s busy_at_done: got %b, need 0", name, obs_busy);
            end
            finished = 1;
         end else begin
            checks++;
            if (obs_busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy n=%0d: got %b, need 1", name, n, obs_busy);
            end
         end
         if (obs_ram_en === 1'b1) begin
            checks++;
            if (issued - xfer >= 4) begin
               errors++;
               $display("FAIL %s credit n=%0d: got %0d outstanding at issue, need <4", name, n, issued - xfer);
            end
            checks++;
            if (exp_addr_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_read n=%0d: got addr %0d, need no read", name, n, obs_ram_addr);
            end else begin
               exp_a = exp_addr_q.pop_front();
               if (obs_ram_addr !== exp_a) begin
                  errors++;
                  $display("FAIL %s ram_addr n=%0d: got %0d, need %0d", name, n, obs_ram_addr, exp_a);
               end
            end
            issued++;
         end
         if (obs_m_valid === 1'b1 && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_beat n=%0d: got %h, need none", name, n, obs);
            end else begin
               exp = exp_q.pop_front();
               if (obs !== exp) begin
                  errors++;
                  $display("FAIL %s beat n=%0d: got {data,row,col,last}=%h, need %h", name, n, obs, exp);
               end
               if (exp[0]) begin
                  got_last = 1;
                  last_n = n;
               end
            end
            if (first_n < 0) first_n = n;
            xfer++;
         end
         prev_stall = (obs_m_valid === 1'b1) && !m_ready;
         held = obs;
         n++;
      end
      start = 1'b0;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL %s timeout: got no done in %0d cycles, need done", name, n);
      end
      checks++;
      if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
         errors++;
         $display("FAIL %s leftovers: got %0d beats / %0d reads missing, need 0", name, exp_q.size(), exp_addr_q.size());
      end
      if (ready_pct >= 100) begin
         checks++;
         if (first_n != lat + 1) begin
            errors++;
            $display("FAIL %s first_latency: got %0d, need %0d", name, first_n, lat + 1);
         end
         checks++;
         if (last_n != lat + s * s) begin
            errors++;
            $display("FAIL %s last_beat_cycle: got %0d, need %0d", name, last_n, lat + s * s);
         end
      end
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      checks++;
      if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done: got done=%b busy=%b, need 0 0", name, obs_done, obs_busy);
      end
      repeat (20) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 3'd0; base_addr = '0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({busy_a, done_a, err_a, ram_en_a, m_valid_a, m_last_a, ram_addr_a, m_data_a, m_row_a, m_col_a} !== '0) begin
         errors++;
         $display("FAIL reset_lat1: got busy=%b done=%b err=%b en=%b v=%b last=%b addr=%0d data=%h row=%0d col=%0d, need all 0",
                  busy_a, done_a, err_a, ram_en_a, m_valid_a, m_last_a, ram_addr_a, m_data_a, m_row_a, m_col_a);
      end
      checks++;
      if ({busy_b, done_b, err_b, ram_en_b, m_valid_b, m_last_b, ram_addr_b, m_data_b, m_row_b, m_col_b} !== '0) begin
         errors++;
         $display("FAIL reset_lat2: got busy=%b done=%b err=%b en=%b v=%b last=%b, need all 0",
                  busy_b, done_b, err_b, ram_en_b, m_valid_b, m_last_b);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_small_map();
      fill_random();
      for (int k = 0; k < 25; k++) mem[100 + k] = DW'(k);
      test_stream("map5x5", 1'b0, 4, 100, 100, -1, 0);
   endtask

   task automatic test_full_map_lat2();
      fill_random();
      test_stream("map32_lat2", 1'b1, 0, 0, 100, -1, 0);
   endtask

   task automatic test_back_pressure();
      fill_random();
      test_stream("map10_bp", 1'b0, 3, int'($urandom_range(2047)), 50, 7, 0);
      test_stream("map10_bp_lat2", 1'b1, 3, int'($urandom_range(2047)), 50, 4, 6);
      test_stream("map28_bp", 1'b0, 1, int'($urandom_range(2047)), 70, 30, 7);
   endtask

   task automatic test_addr_wrap();
      fill_random();
      test_stream("wrap", 1'b0, 4, 2040, 100, -1, 0);
      test_stream("wrap_bp_lat2", 1'b1, 4, 2040, 60, -1, 0);
   endtask

   task automatic test_illegal_mode();
      sel_b = 1'b0;
      for (int m = 5; m < 8; m++) begin
         @(negedge clk);
         start = 1'b1; mode = 3'(m); base_addr = AW'($urandom_range(2047));
         @(negedge clk);
         start = 1'b0;
         #1;
         checks++;
         if (obs_err !== 1'b1 || obs_busy !== 1'b0 || obs_ram_en !== 1'b0) begin
            errors++;
            $display("FAIL illegal_mode%0d pulse: got err=%b busy=%b en=%b, need 1 0 0", m, obs_err, obs_busy, obs_ram_en);
         end
         @(negedge clk);
         #1;
         checks++;
         if (obs_err !== 1'b0 || obs_busy !== 1'b0 || obs_ram_en !== 1'b0 || obs_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_mode%0d after: got err=%b busy=%b en=%b v=%b, need 0 0 0 0",
                     m, obs_err, obs_busy, obs_ram_en, obs_m_valid);
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      int beats, n, base;
      sel_b = 1'b0;
      fill_random();
      base = int'($urandom_range(2047));
      @(negedge clk);
      start = 1'b1; mode = 3'd2; base_addr = AW'(base); m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      beats = 0; n = 0;
      while (beats < 7 && n < 100) begin
         @(negedge clk);
         #1;
         if (obs_m_valid === 1'b1 && m_ready) beats++;
         n++;
      end
      checks++;
      if (beats != 7) begin
         errors++;
         $display("FAIL reset_mid beats_before: got %0d, need 7", beats);
      end
      @(negedge clk);
      rst = 1'b1; m_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({busy_a, done_a, err_a, ram_en_a, m_valid_a, m_last_a, ram_addr_a, m_data_a, m_row_a, m_col_a} !== '0) begin
         errors++;
         $display("FAIL reset_mid outputs: got busy=%b done=%b en=%b v=%b addr=%0d data=%h row=%0d col=%0d, need all 0",
                  busy_a, done_a, ram_en_a, m_valid_a, ram_addr_a, m_data_a, m_row_a, m_col_a);
      end
      rst = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (obs_m_valid !== 1'b0 || obs_ram_en !== 1'b0 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid quiet%0d: got v=%b en=%b busy=%b, need 0 0 0", i, obs_m_valid, obs_ram_en, obs_busy);
         end
      end
      test_stream("after_reset", 1'b0, 2, base, 100, -1, 0);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_small_map();
      test_full_map_lat2();
      test_back_pressure();
      test_addr_wrap();
      test_illegal_mode();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by %0t, need completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fmap_stream_reader.md
FMAP_STREAM_READER -- requirements
Module: fmap_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, feature-map RAM address width.
REQ-003 SHALL have parameters FEATURE_MAP1_SIZE..FEATURE_MAP5_SIZE, defaults 32/28/14/10/5, square map side per mode 0..4.
REQ-004 SHALL have parameter RAM_LATENCY, default 1, legal values 1 or 2, cycles from ram_en/ram_addr to valid ram_dout.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to stream one feature map.
- mode  in  3  map select: 0..4 -> FEATURE_MAP1..5_SIZE; 5..7 illegal.
- base_addr  in  ADDR_WIDTH  RAM address of pixel (0,0).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- err_mode  out  1  one-cycle pulse when start arrives with illegal mode.
- ram_en  out  1  read enable to RAM read port.
- ram_addr  out  ADDR_WIDTH  read address to RAM read port.
- ram_dout  in  DATA_WIDTH  read data from RAM.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  pixel value.
- m_row  out  6  pixel row index.
- m_col  out  6  pixel column index.
- m_last  out  1  high on the final pixel of the map.

Function
REQ-007 SHALL latch mode-derived SIZE and base_addr on an accepted start (start=1, busy=0, legal mode); inputs are ignored while busy.
REQ-008 SHALL pulse err_mode for one cycle and stay idle on start with mode 5..7 while not busy.
REQ-009 SHALL implement FSM IDLE -> READ (on accepted start) -> DRAIN (after last address issued) -> DONE (last beat accepted, one cycle) -> IDLE.
REQ-010 SHALL issue reads row-major: index k = row*SIZE+col, ram_addr = (base_addr + k) mod 2^ADDR_WIDTH, k from 0 to SIZE*SIZE-1.
REQ-011 SHALL assert ram_en only in READ, and only when in-flight reads plus occupied output-buffer entries < 4.
REQ-012 SHALL track in-flight reads with a RAM_LATENCY-deep valid/tag shift register and write ram_dout with its row/col/last tag into a 4-entry output FIFO exactly RAM_LATENCY cycles after issue.
REQ-013 SHALL drive m_valid whenever the output FIFO is non-empty; m_data/m_row/m_col/m_last held stable while m_valid=1 and m_ready=0.
REQ-014 SHALL consider a beat transferred when m_valid=1 and m_ready=1; simultaneous FIFO write and read in one cycle SHALL keep occupancy unchanged.
REQ-015 SHALL sustain one beat per cycle when m_ready is held high (first beat RAM_LATENCY+1 cycles after accepted start).
REQ-016 SHALL never drop or duplicate a pixel under arbitrary m_ready backpressure; FIFO never overflows by REQ-011.
REQ-017 SHALL assert m_last only with k = SIZE*SIZE-1 (row=col=SIZE-1).
REQ-018 SHALL pulse done one cycle after the m_last beat is transferred and deassert busy in that same cycle.
REQ-019 SHALL accept a new start in the cycle done is high only if busy=0 there; start in the same cycle as busy falling is ignored.
REQ-020 SHALL wrap ram_addr modulo 2^ADDR_WIDTH when base_addr + k overflows.

Reset
REQ-021 SHALL, on rst=1, force FSM to IDLE and busy, done, err_mode, ram_en, m_valid, m_last to 0, ram_addr, m_data, m_row, m_col to 0, and empty FIFO and in-flight pipeline.
REQ-022 SHALL, on rst mid-stream, discard all in-flight read data; no beat appears after reset release until a new start.

Verification
REQ-023 Mode 4 (5x5), base_addr=100, RAM[100+k]=k, m_ready=1 -> 25 beats data 0..24, row/col row-major, m_last only on 25th, done next cycle.
REQ-024 Mode 0 (32x32), base_addr=0, RAM_LATENCY=2, m_ready=1 -> 1024 consecutive beats one per cycle after 3-cycle initial latency; m_last on (31,31).
REQ-025 Mode 3 (10x10), m_ready random 50% -> 100 beats in order, no gaps/duplicates, data stable under stall, ram_en never issued with 4 entries committed.
REQ-026 Mode 4, base_addr=2040 (ADDR_WIDTH=11) -> ram_addr sequence 2040..2047,0..16.
REQ-027 start with mode=6 -> err_mode pulse, busy stays 0, no ram_en; second start while busy ignored.
REQ-028 rst asserted after 7 beats of mode 2 -> all outputs 0 next cycle, no further beats; new start streams full 196 pixels from index 0.
